measure_bcd_convert: RTL and testbench

//   Sequential binary-to-BCD converter (shift-add-3 / double dabble) downstream of the

---
 rtl/measure_bcd_convert.sv | 108 ++++++++++
 tb/tb_measure_bcd_convert.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/measure_bcd_convert.sv
// Sequential binary-to-BCD converter (double dabble), one bit per clock.
// Produces packed BCD digits and a leading-zero blank mask for the readout.
module measure_bcd_convert #(
  parameter int WIDTH  = 14,
  parameter int DIGITS = 5
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [WIDTH-1:0]      num_in,
  output logic                  busy,
  output logic                  done,
  output logic [DIGITS*4-1:0]   bcd,
  output logic [DIGITS-1:0]     blank
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [DIGITS-1:0] BLANK_RST =
    {{(DIGITS-1){1'b1}}, 1'b0};

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    FINISH
  } state_t;

  state_t              state;
  state_t              state_nx;
  logic [WIDTH-1:0]    bin;
  logic [DIGITS*4-1:0] scratch;
  logic [DIGITS*4-1:0] adj;
  logic [DIGITS-1:0]   mask;
  logic [CW-1:0]       cnt;
  logic                last;
  logic                lead;

  assign last = (cnt == CW'(WIDTH - 1));
  assign busy = (state != IDLE);

  always_comb begin
    adj = scratch;
    for (int i = 0; i < DIGITS; i++) begin
      if (scratch[i*4 +: 4] >= 4'd5)
        adj[i*4 +: 4] = scratch[i*4 +: 4] + 4'd3;
    end
  end

  // Blank from the top digit down until the first non-zero digit.
  always_comb begin
    mask = '0;
    lead = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      lead    = lead & (scratch[i*4 +: 4] == 4'd0);
      mask[i] = lead;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (start) state_nx = SHIFT;
      SHIFT:   if (last) state_nx = FINISH;
      FINISH:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_nx;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      bin     <= '0;
      scratch <= '0;
      cnt     <= '0;
      done    <= 1'b0;
      bcd     <= '0;
      blank   <= BLANK_RST;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            bin     <= num_in;
            scratch <= '0;
            cnt     <= '0;
          end
        end
        SHIFT: begin
          {scratch, bin} <=
            {adj[DIGITS*4-2:0], bin, 1'b0};
          cnt <= cnt + 1'b1;
        end
        FINISH: begin
          bcd   <= scratch;
          blank <= mask;
          done  <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_measure_bcd_convert.sv
// Directed and swept checks for measure_bcd_convert.
// Expected values come from hand tables and a divide-by-ten model.
module tb_measure_bcd_convert;

  logic        clock;
  logic        reset;
  logic        start;
  logic [13:0] num_in;
  logic        busy;
  logic        done;
  logic [19:0] bcd;
  logic [4:0]  blank;

  int checks;
  int errors;

  measure_bcd_convert #(.WIDTH(14), .DIGITS(5)) dut (
    .clock  (clock),
    .reset  (reset),
    .start  (start),
    .num_in (num_in),
    .busy   (busy),
    .done   (done),
    .bcd    (bcd),
    .blank  (blank)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [13:0] num;
    logic [19:0] bcd;
    logic [4:0]  blank;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h",
               name, act, exp);
    end
  endtask

  function automatic logic [19:0] model_bcd(input int v);
    logic [19:0] r;
    int x;
    r = '0;
    x = v;
    for (int i = 0; i < 5; i++) begin
      r[i*4 +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic logic [4:0] model_blank(input logic [19:0] b);
    logic [4:0] m;
    logic z;
    m = '0;
    z = 1'b1;
    for (int i = 4; i >= 1; i--) begin
      z = z && (b[i*4 +: 4] == 4'd0);
      m[i] = z;
    end
    return m;
  endfunction

  // One full conversion from IDLE; checks latency, result and busy.
  task automatic convert(input logic [13:0] v,
                         input logic [19:0] eb,
                         input logic [4:0] ebl,
                         input string tag);
    int lat;
    lat = 0;
    @(negedge clock);
    start  = 1'b1;
    num_in = v;
    @(posedge clock);
    #1;
    start = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clock);
      #1;
      if (done) begin
        lat = k;
        break;
      end
    end
    check({tag, " latency"}, lat, 15);
    check({tag, " bcd"}, bcd, eb);
    check({tag, " blank"}, blank, ebl);
    check({tag, " busy"}, busy, 0);
  endtask

  initial begin
    int ndone, first, prev, badint, badbusy, badval, lat;
    logic [19:0] eb;
    logic [19:0] held;
    logic [13:0] rv;
    checks = 0;
    errors = 0;

    vecs[0] = '{14'd0,     20'h00000, 5'b11110};
    vecs[1] = '{14'd16383, 20'h16383, 5'b00000};
    vecs[2] = '{14'd42,    20'h00042, 5'b11100};
    vecs[3] = '{14'd10000, 20'h10000, 5'b00000};
    vecs[4] = '{14'd9999,  20'h09999, 5'b10000};
    vecs[5] = '{14'd7,     20'h00007, 5'b11110};
    vecs[6] = '{14'd100,   20'h00100, 5'b11000};
    vecs[7] = '{14'd1234,  20'h01234, 5'b10000};
    vecs[8] = '{14'd9,     20'h00009, 5'b11110};
    vecs[9] = '{14'd10,    20'h00010, 5'b11100};

    reset  = 1'b1;
    start  = 1'b0;
    num_in = '0;
    repeat (2) @(posedge clock);
    #1;
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset bcd", bcd, 0);
    check("reset blank", blank, 5'b11110);
    reset = 1'b0;

    for (int i = 0; i < 10; i++)
      convert(vecs[i].num, vecs[i].bcd, vecs[i].blank,
              $sformatf("vec%0d", i));

    // start held high continuously
    @(negedge clock);
    start  = 1'b1;
    num_in = 14'd9999;
    ndone = 0; first = 0; prev = 0;
    badint = 0; badbusy = 0; badval = 0;
    for (int c = 1; c <= 64; c++) begin
      @(posedge clock);
      #1;
      if (busy !== 1'b1 && done !== 1'b1) badbusy++;
      if (busy === 1'b1 && done === 1'b1) badbusy++;
      if (done) begin
        ndone++;
        if (first == 0) first = c;
        else if (c - prev != 16) badint++;
        prev = c;
        if (bcd !== 20'h09999 || blank !== 5'b10000)
          badval++;
      end
    end
    @(negedge clock);
    start = 1'b0;
    repeat (20) @(posedge clock);
    check("cont first done", first, 16);
    check("cont done count", ndone, 4);
    check("cont interval", badint, 0);
    check("cont busy gap", badbusy, 0);
    check("cont value", badval, 0);

    // start while busy is ignored, num_in change ignored
    @(negedge clock);
    start  = 1'b1;
    num_in = 14'd123;
    @(posedge clock);
    #1;
    start = 1'b0;
    ndone = 0; lat = 0; held = '0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clock);
      #1;
      if (k == 5) begin
        num_in = 14'd456;
        start  = 1'b1;
      end
      if (k == 6) start = 1'b0;
      if (done) begin
        ndone++;
        if (lat == 0) begin
          lat  = k;
          held = bcd;
        end
      end
    end
    check("busy-start done count", ndone, 1);
    check("busy-start latency", lat, 15);
    check("busy-start bcd", held, 20'h00123);
    check("busy-start bcd held", bcd, 20'h00123);

    // reset mid-conversion
    @(negedge clock);
    start  = 1'b1;
    num_in = 14'd555;
    @(posedge clock);
    #1;
    start = 1'b0;
    ndone = 0;
    for (int k = 1; k <= 7; k++) begin
      @(posedge clock);
      #1;
      if (done) ndone++;
      if (k == 7) reset = 1'b1;
    end
    @(posedge clock);
    #1;
    reset = 1'b0;
    check("midreset busy", busy, 0);
    check("midreset done", done, 0);
    check("midreset bcd", bcd, 0);
    check("midreset blank", blank, 5'b11110);
    for (int k = 0; k < 20; k++) begin
      @(posedge clock);
      #1;
      if (done) ndone++;
    end
    check("midreset no done", ndone, 0);
    convert(14'd321, 20'h00321, 5'b11000, "after reset");

    for (int n = 0; n < 1000; n++) begin
      rv = 14'($urandom_range(0, 16383));
      eb = model_bcd(int'(rv));
      convert(rv, eb, model_blank(eb),
              $sformatf("rand %0d", rv));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
